// File: rtl/e_mdu_if.sv
// Operand, opcode and status bundle between the execute stage and the multiply/divide unit.
interface e_mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  opMDU;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUresult;

  modport master (output SrcA, SrcB, opMDU, Start, input Busy, MDUresult);
  modport slave  (input SrcA, SrcB, opMDU, Start, output Busy, MDUresult);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are computed at accept,
// held in pending registers, and committed to HI/LO when the busy countdown expires.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [31:0] a, b;
  assign a = bus.SrcA;
  assign b = bus.SrcB;

  // Full-width products
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Divisor is forced to 1 for the zero and INT_MIN/-1 cases so the dividers never see them
  logic               div_zero, div_ovf;
  logic        [31:0] b_safe;
  logic signed [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;
  assign div_zero = (b == 32'h0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe   = (div_zero || div_ovf) ? 32'h1 : b;
  assign q_s      = $signed(a) / $signed(b_safe);
  assign r_s      = $signed(a) % $signed(b_safe);
  assign q_u      = a / b_safe;
  assign r_u      = a % b_safe;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d    = 1'b0;
        cnt_d     = '0;
        pend_wr_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      unique case (bus.opMDU)
        OP_MULT, OP_MULTU: begin
          if (bus.Start) begin
            busy_d    = 1'b1;
            cnt_d     = CNT_W'(MULT_CYCLES);
            pend_wr_d = 1'b1;
            if (bus.opMDU == OP_MULT) {pend_hi_d, pend_lo_d} = prod_s;
            else                      {pend_hi_d, pend_lo_d} = prod_u;
          end
        end
        OP_DIV, OP_DIVU: begin
          if (bus.Start) begin
            busy_d    = 1'b1;
            cnt_d     = CNT_W'(DIV_CYCLES);
            pend_wr_d = !div_zero;
            if (bus.opMDU == OP_DIVU) begin
              pend_lo_d = q_u;
              pend_hi_d = r_u;
            end else if (div_ovf) begin
              pend_lo_d = 32'h8000_0000;
              pend_hi_d = 32'h0;
            end else begin
              pend_lo_d = q_s;
              pend_hi_d = r_s;
            end
          end
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.MDUresult = (bus.opMDU == OP_MFHI) ? hi_q :
                         (bus.opMDU == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: stimulus queues expected Busy/MDUresult values tagged with a cycle,
// and a negedge monitor pops and compares them.
module tb_e_mdu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus ();
  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          cyc;
    bit          is_res;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.is_res ? bus.MDUresult : {31'h0, bus.Busy};
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s: cycle %0d got %h expected %h (due cycle %0d)", e.name, cyc, act, e.exp, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_busy(input logic v, input string nm);
    sb.push_back('{cyc, 1'b0, {31'h0, v}, nm});
  endtask

  task automatic exp_res(input logic [31:0] v, input string nm);
    sb.push_back('{cyc, 1'b1, v, nm});
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] v, input string nm);
    bus.opMDU = op;
    exp_res(v, nm);
    step();
    bus.opMDU = 4'd0;
  endtask

  task automatic wr(input logic [3:0] op, input logic [31:0] v);
    bus.opMDU = op;
    bus.SrcA  = v;
    step();
    bus.opMDU = 4'd0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    bus.opMDU = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.Start = 1'b1;
    exp_busy(1'b0, nm);
    step();
    bus.Start = 1'b0;
    bus.opMDU = 4'd0;
  endtask

  // n busy cycles after accept; optional read at busy cycle rd_at
  task automatic wait_busy(input int n, input int rd_at, input logic [3:0] rd_op,
                           input logic [31:0] rd_v, input string nm);
    for (int i = 1; i <= n; i++) begin
      exp_busy(1'b1, nm);
      if (i == rd_at) begin
        bus.opMDU = rd_op;
        exp_res(rd_v, {nm, "_rd_during_busy"});
      end
      step();
      bus.opMDU = 4'd0;
    end
    exp_busy(1'b0, {nm, "_done"});
  endtask

  initial begin
    reset     = 1'b1;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    bus.opMDU = 4'd0;
    bus.Start = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    exp_busy(1'b0, "reset_busy");
    exp_res(32'h0, "idle_result");
    step();
    rd(4'd5, 32'h0, "reset_hi");
    rd(4'd6, 32'h0, "reset_lo");

    issue(4'd1, 32'hFFFF_FFFF, 32'h2, "mult");
    wait_busy(5, 0, 4'd0, 32'h0, "mult");
    rd(4'd5, 32'hFFFF_FFFF, "mult_hi");
    rd(4'd6, 32'hFFFF_FFFE, "mult_lo");

    wr(4'd8, 32'h0000_5555);
    rd(4'd6, 32'h0000_5555, "mtlo");
    issue(4'd2, 32'hFFFF_FFFF, 32'h2, "multu");
    wait_busy(5, 3, 4'd6, 32'h0000_5555, "multu");
    rd(4'd5, 32'h0000_0001, "multu_hi");
    rd(4'd6, 32'hFFFF_FFFE, "multu_lo");

    issue(4'd3, 32'hFFFF_FFF9, 32'h2, "div");
    wait_busy(10, 0, 4'd0, 32'h0, "div");
    rd(4'd6, 32'hFFFF_FFFD, "div_lo");
    rd(4'd5, 32'hFFFF_FFFF, "div_hi");

    issue(4'd4, 32'h7, 32'h2, "divu");
    wait_busy(10, 0, 4'd0, 32'h0, "divu");
    rd(4'd6, 32'h3, "divu_lo");
    rd(4'd5, 32'h1, "divu_hi");

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    wait_busy(10, 0, 4'd0, 32'h0, "div_ovf");
    rd(4'd6, 32'h8000_0000, "div_ovf_lo");
    rd(4'd5, 32'h0, "div_ovf_hi");

    issue(4'd1, 32'hFFFF_FFFD, 32'h5, "mult_neg");
    wait_busy(5, 0, 4'd0, 32'h0, "mult_neg");
    rd(4'd5, 32'hFFFF_FFFF, "mult_neg_hi");
    rd(4'd6, 32'hFFFF_FFF1, "mult_neg_lo");

    issue(4'd9, 32'h1, 32'h1, "op9_start");
    exp_busy(1'b0, "op9_no_busy");
    step();
    rd(4'd6, 32'hFFFF_FFF1, "op9_lo_kept");

    // Divide by zero, with mthi/mtlo attempts that must be ignored while busy
    wr(4'd7, 32'h0000_1234);
    issue(4'd3, 32'h5, 32'h0, "div0");
    for (int i = 1; i <= 10; i++) begin
      exp_busy(1'b1, "div0");
      if (i == 5) begin bus.opMDU = 4'd7; bus.SrcA = 32'hAA; end
      if (i == 6) begin bus.opMDU = 4'd8; bus.SrcA = 32'hBB; end
      step();
      bus.opMDU = 4'd0;
    end
    exp_busy(1'b0, "div0_done");
    rd(4'd5, 32'h0000_1234, "div0_hi");
    rd(4'd6, 32'hFFFF_FFF1, "div0_lo");

    // Start mult and mtlo during a divide must not disturb it
    issue(4'd3, 32'd100, 32'd7, "div_busy");
    for (int i = 1; i <= 10; i++) begin
      exp_busy(1'b1, "div_busy");
      if (i == 4) begin bus.Start = 1'b1; bus.opMDU = 4'd1; bus.SrcA = 32'h2; bus.SrcB = 32'h3; end
      if (i == 5) begin bus.opMDU = 4'd8; bus.SrcA = 32'hAA; end
      step();
      bus.Start = 1'b0;
      bus.opMDU = 4'd0;
    end
    exp_busy(1'b0, "div_busy_done");
    rd(4'd6, 32'd14, "div_busy_lo");
    rd(4'd5, 32'd2, "div_busy_hi");

    // Reset in the middle of a multiply
    issue(4'd1, 32'd3, 32'd4, "mult_rst");
    exp_busy(1'b1, "mult_rst_c1");
    step();
    exp_busy(1'b1, "mult_rst_c2");
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_busy(1'b0, "rst_abort_busy");
    rd(4'd5, 32'h0, "rst_abort_hi");
    rd(4'd6, 32'h0, "rst_abort_lo");
    for (int i = 0; i < 6; i++) begin
      exp_busy(1'b0, "rst_no_commit");
      step();
    end
    rd(4'd6, 32'h0, "rst_lo_still0");

    issue(4'd1, 32'd3, 32'd4, "mult_after_rst");
    wait_busy(5, 0, 4'd0, 32'h0, "mult_after_rst");
    rd(4'd6, 32'd12, "mult_after_rst_lo");
    rd(4'd5, 32'h0, "mult_after_rst_hi");

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: Busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SrcA  input  32  operand A, rs value, forwarded.
REQ-006 SrcB  input  32  operand B, rt value, forwarded.
REQ-007 opMDU  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-008 Start  input  1  qualifies opMDU 1-4 for one cycle; ignored for other ops.
REQ-009 Busy  output  1  registered; high while an operation is in progress.
REQ-010 MDUresult  output  32  combinational read of HI (mfhi) or LO (mflo), else 0.

Function
REQ-011 State SHALL be 32-bit HI, 32-bit LO, one pending-op register, and a cycle counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-012 Accept: Start=1, Busy=0, opMDU in 1-4. On that edge, latch the result into pending HI/LO, load the counter with the op's cycle count, and set Busy=1 from the next cycle.
REQ-013 Busy SHALL stay 1 for exactly MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) consecutive cycles after the accept edge.
REQ-014 On the edge where the counter reaches 0, copy pending HI/LO into HI/LO and drop Busy to 0 on the same edge.
REQ-015 HI/LO SHALL be architecturally unchanged until completion. An mfhi/mflo during Busy returns the old value; hazard logic stalls on Start|Busy.
REQ-016 mult: {HI,LO} = signed(SrcA) * signed(SrcB), full 64-bit product. multu uses the unsigned product.
REQ-017 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. divu uses unsigned quotient and remainder.
REQ-018 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero (SrcB=0, div or divu) SHALL run the full DIV_CYCLES with Busy, then leave HI and LO unchanged.
REQ-020 Start while Busy=1 SHALL be ignored: no restart and no counter reload.
REQ-021 mthi writes HI=SrcA and mtlo writes LO=SrcA at the edge, only when Busy=0; ignored when Busy=1.
REQ-022 Same-cycle mthi/mtlo and completion cannot occur (REQ-021 blocks the write); the completion write wins by construction.
REQ-023 MDUresult SHALL be HI when opMDU=5, LO when opMDU=6, else 32'h0, with no extra latency.
REQ-024 opMDU 0 or 9-15 SHALL cause no state change.

Reset
REQ-025 When reset=1 at an edge, the block SHALL clear HI, LO, pending registers, counter and Busy to 0, overriding Start and mthi/mtlo.
REQ-026 Reset asserted mid-operation SHALL abort the operation; HI/LO SHALL read 0 afterwards and the aborted result is never committed.
REQ-027 After reset deasserts, the next Start SHALL be accepted immediately.

Verification
REQ-028 mult with SrcA=0xFFFFFFFF (-1), SrcB=0x00000002, Start=1 -> Busy high for cycles 1-5 only; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-029 multu with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; an mflo in cycle 3 returns the prior LO.
REQ-030 div with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with 7 and 2 -> LO=3, HI=1.
REQ-031 mthi 0x1234, then div by 0 -> Busy for 10 cycles; afterwards mfhi returns 0x1234 and LO keeps its old value.
REQ-032 Start div, then at cycle 4 drive Start mult plus mtlo 0xAA -> both ignored; the div result commits at cycle 10.
REQ-033 Start mult, assert reset at cycle 2 -> Busy=0 the next cycle and HI=LO=0; a new mult accepted right after reset completes normally.
